// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared constants, FSM state encoding and byte arithmetic
//                helper for the RC4 keystream generator.
//  Revision    : 1.0  initial release
// ============================================================================
package rc4_pkg;

    localparam int SBOX_DEPTH   = 256;
    localparam int BYTE_W       = 8;
    // Clock edges from the edge that samples start to the first ks_valid.
    localparam int PRGA_LATENCY = 514;

    // FSM encoding kept as plain constants so older flows can consume it.
    typedef logic [2:0] rc4_state_t;

    localparam rc4_state_t ST_IDLE      = 3'd0;
    localparam rc4_state_t ST_INIT      = 3'd1;
    localparam rc4_state_t ST_KSA       = 3'd2;
    localparam rc4_state_t ST_PRGA_SWAP = 3'd3;
    localparam rc4_state_t ST_PRGA_OUT  = 3'd4;

    // Every RC4 sum is modulo 256: carries are simply dropped.
    function automatic logic [BYTE_W-1:0] add8(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
        return a + b;
    endfunction

endpackage : rc4_pkg
`default_nettype wire

// File: rtl/rc4_sbox_rf.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_sbox_rf
//  Description : 256 x 8 RC4 permutation register file.
//                - two combinational read ports (a, b)
//                - init write port (used while filling S[n] = n)
//                - single-cycle swap port: S[a] <= S[b], S[b] <= S[a]
//                The array has no reset; the INIT phase rewrites it.
//  Ports       : clk                         clock, rising edge
//                i_rd_addr_a/o_rd_data_a     read port a
//                i_rd_addr_b/o_rd_data_b     read port b
//                i_init_we/addr/data         init write port
//                i_swap_en/addr_a/addr_b     swap port
//  Revision    : 1.0  initial release
// ============================================================================
module rc4_sbox_rf
    import rc4_pkg::*;
(
    input  logic              clk,
    input  logic [BYTE_W-1:0] i_rd_addr_a,
    output logic [BYTE_W-1:0] o_rd_data_a,
    input  logic [BYTE_W-1:0] i_rd_addr_b,
    output logic [BYTE_W-1:0] o_rd_data_b,
    input  logic              i_init_we,
    input  logic [BYTE_W-1:0] i_init_addr,
    input  logic [BYTE_W-1:0] i_init_data,
    input  logic              i_swap_en,
    input  logic [BYTE_W-1:0] i_swap_addr_a,
    input  logic [BYTE_W-1:0] i_swap_addr_b
);

    logic [BYTE_W-1:0] r_mem [SBOX_DEPTH];

    assign o_rd_data_a = r_mem[i_rd_addr_a];
    assign o_rd_data_b = r_mem[i_rd_addr_b];

    always_ff @(posedge clk) begin
        if (i_init_we) begin
            r_mem[i_init_addr] <= i_init_data;
        end else if (i_swap_en && (i_swap_addr_a != i_swap_addr_b)) begin
            // Both right-hand sides are pre-edge values, so this is a true swap.
            r_mem[i_swap_addr_a] <= r_mem[i_swap_addr_b];
            r_mem[i_swap_addr_b] <= r_mem[i_swap_addr_a];
        end
    end

endmodule : rc4_sbox_rf
`default_nettype wire

// File: rtl/rc4_stream_core.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_stream_core
//  Description : Parametrised RC4 keystream generator. One FSM runs S-box
//                init, the key schedule and the PRGA, delivering an unbounded
//                keystream over a valid/ready interface.
//  Ports       : clk, rst_n          clock / async active-low reset
//                start, stop         session begin (IDLE only) / abort
//                key, key_length     key bus (byte n at [8n+7:8n]) and length
//                ks_data, ks_valid,  keystream byte stream
//                ks_ready
//                busy                not IDLE
//                ksa_done            PRGA entered, until IDLE
//                err                 sticky illegal key_length flag
//  Revision    : 1.0  initial release
// ============================================================================
module rc4_stream_core
    import rc4_pkg::*;
#(
    parameter int MAX_KEY_BYTES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            stop,
    input  logic [MAX_KEY_BYTES*BYTE_W-1:0] key,
    input  logic [7:0]                      key_length,
    output logic [BYTE_W-1:0]               ks_data,
    output logic                            ks_valid,
    input  logic                            ks_ready,
    output logic                            busy,
    output logic                            ksa_done,
    output logic                            err
);

    localparam logic [7:0] C_MAX_LEN = 8'(MAX_KEY_BYTES);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    rc4_state_t                      r_state_q,    w_state_d;
    logic [BYTE_W-1:0]               r_i_q,        w_i_d;
    logic [BYTE_W-1:0]               r_j_q,        w_j_d;
    logic [7:0]                      r_kidx_q,     w_kidx_d;
    logic [7:0]                      r_key_len_q,  w_key_len_d;
    logic [MAX_KEY_BYTES*BYTE_W-1:0] r_key_q,      w_key_d;
    logic [BYTE_W-1:0]               r_t_q,        w_t_d;
    logic [BYTE_W-1:0]               r_ks_data_q,  w_ks_data_d;
    logic                            r_ks_valid_q, w_ks_valid_d;
    logic                            r_ksa_done_q, w_ksa_done_d;
    logic                            r_err_q,      w_err_d;

    // ------------------------------------------------------------------
    // S-box interface
    // ------------------------------------------------------------------
    logic [BYTE_W-1:0] w_rd_addr_a, w_rd_data_a;
    logic [BYTE_W-1:0] w_rd_addr_b, w_rd_data_b;
    logic              w_init_we;
    logic              w_swap_en;
    logic [BYTE_W-1:0] w_swap_addr_a, w_swap_addr_b;

    logic [BYTE_W-1:0] w_key_byte;
    logic [BYTE_W-1:0] w_i_inc;
    logic [BYTE_W-1:0] w_j_ksa;
    logic [BYTE_W-1:0] w_j_prga;
    logic              w_len_legal;
    logic              w_out_free;

    // Selected key byte; plain mux instead of a variable part-select.
    always_comb begin
        w_key_byte = '0;
        for (int k = 0; k < MAX_KEY_BYTES; k++) begin
            if (r_kidx_q == 8'(k)) begin
                w_key_byte = r_key_q[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Address paths are kept outside the FSM block: port b's address in
    // PRGA_SWAP depends on port a's read data, and splitting avoids a
    // false combinational loop through one always block.
    assign w_i_inc     = add8(r_i_q, 8'd1);
    assign w_rd_addr_a = (r_state_q == ST_KSA)       ? r_i_q   :
                         (r_state_q == ST_PRGA_SWAP) ? w_i_inc : r_t_q;
    assign w_j_ksa     = add8(add8(r_j_q, w_rd_data_a), w_key_byte);
    assign w_j_prga    = add8(r_j_q, w_rd_data_a);
    assign w_rd_addr_b = w_j_prga;

    assign w_swap_addr_a = (r_state_q == ST_KSA) ? r_i_q   : w_i_inc;
    assign w_swap_addr_b = (r_state_q == ST_KSA) ? w_j_ksa : w_j_prga;
    assign w_swap_en     = !stop && ((r_state_q == ST_KSA) ||
                                     (r_state_q == ST_PRGA_SWAP));
    assign w_init_we     = !stop && (r_state_q == ST_INIT);

    assign w_len_legal = (key_length != 8'd0) && (key_length <= C_MAX_LEN);
    // Output register can take a new byte if empty or being drained now.
    assign w_out_free  = !r_ks_valid_q || ks_ready;

    rc4_sbox_rf u_sbox (
        .clk           (clk),
        .i_rd_addr_a   (w_rd_addr_a),
        .o_rd_data_a   (w_rd_data_a),
        .i_rd_addr_b   (w_rd_addr_b),
        .o_rd_data_b   (w_rd_data_b),
        .i_init_we     (w_init_we),
        .i_init_addr   (r_i_q),
        .i_init_data   (r_i_q),
        .i_swap_en     (w_swap_en),
        .i_swap_addr_a (w_swap_addr_a),
        .i_swap_addr_b (w_swap_addr_b)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state_q;
        w_i_d        = r_i_q;
        w_j_d        = r_j_q;
        w_kidx_d     = r_kidx_q;
        w_key_len_d  = r_key_len_q;
        w_key_d      = r_key_q;
        w_t_d        = r_t_q;
        w_ks_data_d  = r_ks_data_q;
        w_ks_valid_d = r_ks_valid_q;
        w_ksa_done_d = r_ksa_done_q;
        w_err_d      = r_err_q;

        // A consumed byte leaves the register unless replaced below.
        if (r_ks_valid_q && ks_ready) begin
            w_ks_valid_d = 1'b0;
        end

        case (r_state_q)
            ST_IDLE: begin
                // stop in the same cycle suppresses start entirely.
                if (start && !stop) begin
                    if (w_len_legal) begin
                        w_key_d     = key;
                        w_key_len_d = key_length;
                        w_err_d     = 1'b0;
                        w_i_d       = '0;
                        w_j_d       = '0;
                        w_kidx_d    = '0;
                        w_state_d   = ST_INIT;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end

            ST_INIT: begin
                // r_i_q doubles as the fill counter; it wraps to 0 for KSA.
                w_i_d = w_i_inc;
                if (r_i_q == 8'hFF) begin
                    w_state_d = ST_KSA;
                end
            end

            ST_KSA: begin
                w_i_d    = w_i_inc;
                w_j_d    = w_j_ksa;
                w_kidx_d = (r_kidx_q == (r_key_len_q - 8'd1)) ? 8'd0
                                                              : r_kidx_q + 8'd1;
                if (r_i_q == 8'hFF) begin
                    w_i_d        = '0;
                    w_j_d        = '0;
                    w_ksa_done_d = 1'b1;
                    w_state_d    = ST_PRGA_SWAP;
                end
            end

            ST_PRGA_SWAP: begin
                w_i_d = w_i_inc;
                w_j_d = w_j_prga;
                // After the swap S[i'] holds the old S[j'] and vice versa, so
                // the output index is the sum of the two pre-swap reads.
                w_t_d     = add8(w_rd_data_a, w_rd_data_b);
                w_state_d = ST_PRGA_OUT;
            end

            ST_PRGA_OUT: begin
                if (w_out_free) begin
                    w_ks_data_d  = w_rd_data_a;
                    w_ks_valid_d = 1'b1;
                    w_state_d    = ST_PRGA_SWAP;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (stop && (r_state_q != ST_IDLE)) begin
            w_state_d    = ST_IDLE;
            w_ks_valid_d = 1'b0;
            w_ksa_done_d = 1'b0;
            w_i_d        = '0;
            w_j_d        = '0;
            w_kidx_d     = '0;
        end
    end

    // ------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q    <= ST_IDLE;
            r_i_q        <= '0;
            r_j_q        <= '0;
            r_kidx_q     <= '0;
            r_key_len_q  <= '0;
            r_key_q      <= '0;
            r_t_q        <= '0;
            r_ks_data_q  <= '0;
            r_ks_valid_q <= 1'b0;
            r_ksa_done_q <= 1'b0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_i_q        <= w_i_d;
            r_j_q        <= w_j_d;
            r_kidx_q     <= w_kidx_d;
            r_key_len_q  <= w_key_len_d;
            r_key_q      <= w_key_d;
            r_t_q        <= w_t_d;
            r_ks_data_q  <= w_ks_data_d;
            r_ks_valid_q <= w_ks_valid_d;
            r_ksa_done_q <= w_ksa_done_d;
            r_err_q      <= w_err_d;
        end
    end

    assign ks_data  = r_ks_data_q;
    assign ks_valid = r_ks_valid_q;
    assign busy     = (r_state_q != ST_IDLE);
    assign ksa_done = r_ksa_done_q;
    assign err      = r_err_q;

endmodule : rc4_stream_core
`default_nettype wire

// File: tb/tb_rc4_stream_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rc4_stream_core
//  Description : Scoreboard bench for rc4_stream_core. Stimulus pushes the
//                expected keystream (known vectors or a behavioural RC4
//                model) into a queue; a negedge monitor pops and compares
//                each accepted byte and checks data stability under stall.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rc4_stream_core;
    import rc4_pkg::*;

    localparam int MKB = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [MKB*8-1:0] key;
    logic [7:0]       key_length;
    logic [7:0]       ks_data;
    logic             ks_valid;
    logic             ks_ready;
    logic             busy;
    logic             ksa_done;
    logic             err;

    rc4_stream_core #(.MAX_KEY_BYTES(MKB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .key        (key),
        .key_length (key_length),
        .ks_data    (ks_data),
        .ks_valid   (ks_valid),
        .ks_ready   (ks_ready),
        .busy       (busy),
        .ksa_done   (ksa_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0] exp_q[$];
    int         acc_cyc_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_acc    = 0;
    int         sess_base = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Behavioural RC4: textbook KSA + PRGA over an int array.
    task automatic ref_push(input logic [MKB*8-1:0] k, input int len, input int n);
        int s[256];
        int i, j, tmp;
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + int'(k[8*(x % len) +: 8])) % 256;
            tmp = s[x]; s[x] = s[j]; s[j] = tmp;
        end
        i = 0;
        j = 0;
        for (int x = 0; x < n; x++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            tmp = s[i]; s[i] = s[j]; s[j] = tmp;
            exp_q.push_back(8'(s[(s[i] + s[j]) % 256]));
        end
    endtask

    // ---------------- monitor ----------------
    logic       held_v = 1'b0;
    logic [7:0] held_d = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (held_v) begin
                chk("hold_valid", int'(ks_valid), 1);
                chk("hold_data", int'(ks_data), int'(held_d));
            end
            if (ks_valid && ks_ready) begin
                n_acc++;
                acc_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h with empty scoreboard", ks_data);
                end else begin
                    chk("ks_byte", int'(ks_data), int'(exp_q.pop_front()));
                end
            end
            held_v = ks_valid && !ks_ready && !stop;
            held_d = ks_data;
        end else begin
            held_v = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [MKB*8-1:0] junk_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the sampling edge (edge 0).
    task automatic start_session(input logic [MKB*8-1:0] k, input logic [7:0] len);
        key        = k;
        key_length = len;
        start      = 1'b1;
        sess_base  = n_acc;
        @(posedge clk);
        #1;
        start      = 1'b0;
        key        = junk_key();
        key_length = 8'($urandom_range(0, 255));
    endtask

    task automatic run_until(input int n, input int pct);
        int cnt;
        cnt = 0;
        while ((n_acc < sess_base + n) && (cnt < 20000)) begin
            ks_ready = ($urandom_range(0, 99) < pct);
            @(posedge clk);
            #1;
            cnt++;
        end
        ks_ready = 1'b0;
        chk("session_bytes", n_acc - sess_base, n);
    endtask

    task automatic end_session();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_valid", int'(ks_valid), 0);
        chk("stop_ksa_done", int'(ksa_done), 0);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    logic [7:0]       v_key[10]   = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    logic [7:0]       v_wiki[6]   = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
    logic [7:0]       v_secret[8] = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};
    logic [MKB*8-1:0] kv;

    task automatic push_key3();
        for (int x = 0; x < 3; x++) exp_q.push_back(v_key[x]);
    endtask

    function automatic logic [MKB*8-1:0] key_key();
        logic [MKB*8-1:0] r;
        r = junk_key();
        r[23:0] = 24'h79654B;
        return r;
    endfunction

    initial begin
        int cnt;
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        ks_ready   = 1'b0;
        key        = '0;
        key_length = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(ks_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ksa_done", int'(ksa_done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_data", int'(ks_data), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: "Key", latency and full-rate throughput
        foreach (v_key[x]) exp_q.push_back(v_key[x]);
        acc_cyc_q.delete();
        ks_ready = 1'b1;
        start_session(key_key(), 8'd3);
        cnt = 0;
        while (cnt < 2000) begin
            @(posedge clk);
            cnt++;
            #1;
            if (ks_valid) break;
        end
        chk("first_valid_edge", cnt, PRGA_LATENCY);
        chk("ksa_done_in_prga", int'(ksa_done), 1);
        chk("busy_in_prga", int'(busy), 1);
        run_until(10, 100);
        if (acc_cyc_q.size() >= 10) chk("throughput_span", acc_cyc_q[9] - acc_cyc_q[0], 18);
        else chk("throughput_count", acc_cyc_q.size(), 10);
        end_session();

        // 2: "Wiki" with light backpressure
        foreach (v_wiki[x]) exp_q.push_back(v_wiki[x]);
        kv = junk_key();
        kv[31:0] = 32'h696B6957;
        start_session(kv, 8'd4);
        run_until(6, 70);
        end_session();

        // 3: "Secret"; an illegal start mid-session must be ignored
        foreach (v_secret[x]) exp_q.push_back(v_secret[x]);
        kv = junk_key();
        kv[47:0] = 48'h746572636553;
        start_session(kv, 8'd6);
        repeat (100) @(posedge clk);
        #1;
        key_length = 8'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_while_busy_err", int'(err), 0);
        chk("start_while_busy_busy", int'(busy), 1);
        run_until(8, 60);
        end_session();

        // 4: random 16-byte key, heavy random backpressure, 1000 bytes
        kv = junk_key();
        ref_push(kv, 16, 1000);
        start_session(kv, 8'd16);
        run_until(1000, 50);
        end_session();

        // 4b: random key length
        cnt = $urandom_range(1, 16);
        kv = junk_key();
        ref_push(kv, cnt, 300);
        start_session(kv, 8'(cnt));
        run_until(300, 80);
        end_session();

        // stop and start together in IDLE: stop wins, err untouched
        key_length = 8'd0;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        chk("stop_wins_busy", int'(busy), 0);
        chk("stop_wins_err", int'(err), 0);

        // 5: illegal lengths, then a legal start clears err
        start_session(junk_key(), 8'd0);
        chk("len0_err", int'(err), 1);
        chk("len0_busy", int'(busy), 0);
        start_session(junk_key(), 8'd17);
        chk("len17_err", int'(err), 1);
        chk("len17_busy", int'(busy), 0);
        push_key3();
        start_session(key_key(), 8'd3);
        chk("legal_err_clear", int'(err), 0);
        chk("legal_busy", int'(busy), 1);
        run_until(3, 100);
        end_session();

        // 6: stop at edge 300 (mid-KSA)
        start_session(key_key(), 8'd3);
        repeat (299) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("ksa_stop_busy", int'(busy), 0);
        chk("ksa_stop_valid", int'(ks_valid), 0);
        chk("ksa_stop_ksa_done", int'(ksa_done), 0);
        push_key3();
        start_session(key_key(), 8'd3);
        run_until(3, 100);
        // stalled mid-PRGA, then async reset
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", int'(ks_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ksa_done", int'(ksa_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_key3();
        start_session(key_key(), 8'd3);
        run_until(3, 100);
        end_session();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_rc4_stream_core
`default_nettype wire
